// File: rtl/branch_predictor.sv
// Fetch-stage BTB with 2-bit saturating counters plus a saturating mispredict counter.
// Prediction is combinational (0 cycles); training lands 1 cycle later. There is no backpressure: one update is accepted every cycle.
module branch_predictor #(
    parameter int IDX_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      if_pc,
    output logic             pred_hit,
    output logic             pred_taken,
    output logic [31:0]      pred_target,
    input  logic             upd_valid,
    input  logic [31:0]      upd_pc,
    input  logic             upd_taken,
    input  logic [31:0]      upd_target,
    input  logic             upd_pred_taken,
    output logic             mispredict,
    output logic [CNT_W-1:0] mispredict_cnt
);
    localparam int ENTRIES = 2**IDX_W;
    localparam int TAG_W   = 30 - IDX_W;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [31:0]      target;
        logic [1:0]       ctr;
    } entry_t;

    entry_t           tbl [ENTRIES];
    logic [IDX_W-1:0] if_idx;
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] if_tag;
    logic [TAG_W-1:0] upd_tag;
    entry_t           if_ent;
    entry_t           upd_ent;
    entry_t           upd_nxt;
    logic             upd_hit;
    logic             upd_we;
    logic             mis_evt;
    logic             unused_pc_lsbs;

    assign unused_pc_lsbs = ^{if_pc[1:0], upd_pc[1:0]};

    assign if_idx  = if_pc[IDX_W+1:2];
    assign if_tag  = if_pc[31:IDX_W+2];
    assign upd_idx = upd_pc[IDX_W+1:2];
    assign upd_tag = upd_pc[31:IDX_W+2];

    // Reads see the pre-update table: a same-cycle write to this index is not bypassed.
    assign if_ent      = tbl[if_idx];
    assign pred_hit    = if_ent.valid && (if_ent.tag == if_tag);
    assign pred_taken  = pred_hit && if_ent.ctr[1];
    assign pred_target = pred_taken ? if_ent.target : 32'h0;

    assign upd_ent = tbl[upd_idx];
    assign upd_hit = upd_ent.valid && (upd_ent.tag == upd_tag);

    always_comb begin
        upd_nxt = upd_ent;
        upd_we  = 1'b0;
        if (upd_valid) begin
            if (upd_hit) begin
                upd_we = 1'b1;
                if (upd_taken) begin
                    upd_nxt.target = upd_target;
                    if (upd_ent.ctr != 2'b11) upd_nxt.ctr = upd_ent.ctr + 2'd1;
                end else if (upd_ent.ctr != 2'b00) begin
                    upd_nxt.ctr = upd_ent.ctr - 2'd1;
                end
            end else if (upd_taken) begin
                // Allocation evicts whatever aliased entry was there.
                upd_we  = 1'b1;
                upd_nxt = '{valid: 1'b1, tag: upd_tag, target: upd_target, ctr: 2'b10};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                tbl[i] <= '{valid: 1'b0, tag: '0, target: 32'h0, ctr: 2'b01};
            end
        end else if (upd_we) begin
            tbl[upd_idx] <= upd_nxt;
        end
    end

    assign mis_evt = upd_valid && (upd_pred_taken != upd_taken);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mispredict     <= 1'b0;
            mispredict_cnt <= '0;
        end else begin
            mispredict <= mis_evt;
            if (mis_evt && (mispredict_cnt != '1)) mispredict_cnt <= mispredict_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboarded bench for branch_predictor (IDX_W=4, CNT_W=4).
// Predictions are checked mid-cycle; registered mispredict outputs are checked the following cycle.
module tb_branch_predictor;
    logic        clk;
    logic        rst_n;
    logic [31:0] if_pc;
    logic        pred_hit;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic        mispredict;
    logic [3:0]  mispredict_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int model_cnt = 0;

    logic [33:0] pred_q [$];
    string       tag_q  [$];
    logic [4:0]  mis_q  [$];

    branch_predictor #(.IDX_W(4), .CNT_W(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .if_pc          (if_pc),
        .pred_hit       (pred_hit),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_taken      (upd_taken),
        .upd_target     (upd_target),
        .upd_pred_taken (upd_pred_taken),
        .mispredict     (mispredict),
        .mispredict_cnt (mispredict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_mis();
        logic [4:0] e;
        if (mis_q.size() > 0) begin
            e = mis_q.pop_front();
            check("mispredict", {31'h0, mispredict}, {31'h0, e[4]});
            check("mispredict_cnt", {28'h0, mispredict_cnt}, {28'h0, e[3:0]});
        end
    endtask

    // One clock cycle: drive the fetch PC and an optional update, check the prediction.
    task automatic cyc(input string t, input logic [31:0] pc,
                       input logic uv, input logic [31:0] upc, input logic ut,
                       input logic [31:0] utgt, input logic upt,
                       input logic eh, input logic et, input logic [31:0] etgt);
        logic [33:0] e;
        string       et_tag;
        logic        em;
        @(negedge clk);
        check_mis();
        if_pc = pc; upd_valid = uv; upd_pc = upc; upd_taken = ut;
        upd_target = utgt; upd_pred_taken = upt;
        pred_q.push_back({eh, et, etgt});
        tag_q.push_back(t);
        em = uv && (upt != ut);
        if (em && model_cnt != 15) model_cnt++;
        mis_q.push_back({em, 4'(model_cnt)});
        #1;
        e = pred_q.pop_front();
        et_tag = tag_q.pop_front();
        check({et_tag, "_hit"},    {31'h0, pred_hit},   {31'h0, e[33]});
        check({et_tag, "_taken"},  {31'h0, pred_taken}, {31'h0, e[32]});
        check({et_tag, "_target"}, pred_target,         e[31:0]);
    endtask

    task automatic probe(input string t, input logic [31:0] pc,
                         input logic eh, input logic et, input logic [31:0] etgt);
        cyc(t, pc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, eh, et, etgt);
    endtask

    initial begin
        rst_n = 1'b0; if_pc = 32'h40; upd_valid = 1'b0; upd_pc = 32'h0;
        upd_taken = 1'b0; upd_target = 32'h0; upd_pred_taken = 1'b0;
        #12;
        check("rst_mispredict", {31'h0, mispredict}, 32'h0);
        check("rst_cnt", {28'h0, mispredict_cnt}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        probe("reset_probe", 32'h40, 1'b0, 1'b0, 32'h0);
        // First allocation: mispredicted (pred 0, actual taken)
        cyc("alloc_same", 32'h40, 1'b1, 32'h40, 1'b1, 32'h20, 1'b0, 1'b0, 1'b0, 32'h0);
        probe("alloc_vis", 32'h40, 1'b1, 1'b1, 32'h20);
        for (int i = 0; i < 3; i++)
            cyc("sat_up", 32'h40, 1'b1, 32'h40, 1'b1, 32'h20, 1'b1, 1'b1, 1'b1, 32'h20);
        for (int i = 0; i < 2; i++)
            cyc("sat_dn", 32'h40, 1'b1, 32'h40, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h20);
        probe("ctr1", 32'h40, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 2; i++)
            cyc("floor", 32'h40, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
        cyc("from0", 32'h40, 1'b1, 32'h40, 1'b1, 32'h20, 1'b0, 1'b1, 1'b0, 32'h0);
        probe("ctr1_again", 32'h40, 1'b1, 1'b0, 32'h0);
        cyc("retarget", 32'h40, 1'b1, 32'h40, 1'b1, 32'h28, 1'b0, 1'b1, 1'b0, 32'h0);
        probe("retarget_vis", 32'h40, 1'b1, 1'b1, 32'h28);
        cyc("upd_invalid", 32'h40, 1'b0, 32'h40, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h28);
        probe("upd_invalid_vis", 32'h40, 1'b1, 1'b1, 32'h28);
        // 0x440 shares index 0 with 0x40 but has a different tag
        cyc("alias_same", 32'h440, 1'b1, 32'h440, 1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0);
        probe("alias_old", 32'h40, 1'b0, 1'b0, 32'h0);
        probe("alias_new", 32'h440, 1'b1, 1'b1, 32'h100);
        cyc("miss_nt", 32'h440, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h100);
        probe("miss_nt_vis", 32'h440, 1'b1, 1'b1, 32'h100);
        cyc("rw_same", 32'h80, 1'b1, 32'h80, 1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 32'h0);
        probe("rw_next", 32'h80, 1'b1, 1'b1, 32'h200);
        probe("rw_evicted", 32'h440, 1'b0, 1'b0, 32'h0);
        // 17 mispredicting not-taken misses at an empty index; the 4-bit counter pins at 0xF
        for (int i = 0; i < 17; i++)
            cyc("cnt_sat", 32'h44, 1'b1, 32'h44, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
        probe("cnt_hold0", 32'h80, 1'b1, 1'b1, 32'h200);
        probe("cnt_hold1", 32'h80, 1'b1, 1'b1, 32'h200);
        check("cnt_model_sat", model_cnt, 32'd15);

        // Asynchronous reset pulse between clock edges
        @(negedge clk);
        check_mis();
        #2 rst_n = 1'b0;
        #1;
        check("async_cnt", {28'h0, mispredict_cnt}, 32'h0);
        check("async_mispredict", {31'h0, mispredict}, 32'h0);
        check("async_hit", {31'h0, pred_hit}, 32'h0);
        #1 rst_n = 1'b1;
        model_cnt = 0;
        mis_q.delete();

        cyc("post_rst_nt", 32'h80, 1'b1, 32'h80, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        probe("post_rst_nt_vis", 32'h80, 1'b0, 1'b0, 32'h0);
        cyc("post_rst_t", 32'h80, 1'b1, 32'h80, 1'b1, 32'h300, 1'b1, 1'b0, 1'b0, 32'h0);
        probe("post_rst_t_vis", 32'h80, 1'b1, 1'b1, 32'h300);
        @(negedge clk);
        check_mis();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/branch_predictor.md
# branch_predictor

Fetch-stage branch predictor: a direct-mapped branch target buffer with 2-bit saturating counters. It sits in the IF stage and consumes the branch outcome resolved in the ID stage. Each cycle it gives a combinational taken/target prediction for the fetch PC. It is trained one cycle later by the ID-stage resolution (Branch decision plus computed target). It also keeps a saturating mispredict count for performance monitoring.

## Interface
- IDX_W, 4: index width; ENTRIES = 2**IDX_W table entries
- CNT_W, 16: width of the mispredict counter
- clk  in  1  single clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- if_pc  in  32  current fetch PC (word aligned; bits [1:0] ignored)
- pred_hit  out  1  valid tag match for if_pc (combinational)
- pred_taken  out  1  predicted taken (combinational)
- pred_target  out  32  predicted target; 0 when pred_taken=0 (combinational)
- upd_valid  in  1  ID stage resolved a conditional branch (opcode 7'h63) this cycle
- upd_pc  in  32  PC of the resolved branch
- upd_taken  in  1  resolved outcome (ID-stage Branch)
- upd_target  in  32  resolved taken target (PC + B-immediate)
- upd_pred_taken  in  1  pred_taken value carried down the pipe with this branch
- mispredict  out  1  registered; 1 for the cycle after an update whose upd_pred_taken != upd_taken
- mispredict_cnt  out  CNT_W  registered saturating count of mispredicts

## Operation
- Per entry: valid (1), tag (32-2-IDX_W bits = pc[31:2+IDX_W]), target (32), ctr (2).
- Index = pc[IDX_W+1:2]. Hit = valid[idx] && tag[idx] == pc[31:2+IDX_W].
- Predict: pred_hit = hit(if_pc); pred_taken = pred_hit && ctr[idx][1]; pred_target = pred_taken ? target[idx] : 32'h0.
- Update (when upd_valid=1, at the clock edge):
  - Hit, taken: ctr = min(ctr+1, 3); target = upd_target.
  - Hit, not taken: ctr = max(ctr-1, 0); target unchanged.
  - Miss, taken: allocate. The entry is overwritten even if valid with another tag: valid=1, tag from upd_pc, target=upd_target, ctr=2'b10.
  - Miss, not taken: no state change.
- upd_valid=0: table unchanged, regardless of other upd_* values.
- Mispredict: mispredict <= upd_valid && (upd_pred_taken != upd_taken). mispredict_cnt increments by 1 on the same condition and holds at all-ones.
- Counter encoding: 0 strong-NT, 1 weak-NT, 2 weak-T, 3 strong-T.

## Timing
- Reset (asynchronous, rst_n=0): all valid=0, all ctr=2'b01, targets and tags=0, mispredict=0, mispredict_cnt=0. Consequence: pred_hit=0, pred_taken=0, pred_target=0 for any if_pc.
- Prediction latency 0: a pure combinational function of if_pc and current table state.
- Update latency 1: written at the rising edge where upd_valid=1 and visible to prediction from the next cycle.
- Same-cycle read/write of the same index: prediction uses the pre-update (old) state. There is no bypass.
- mispredict and mispredict_cnt change one edge after the qualifying update cycle.
- Reset asserted mid-operation clears all state immediately, independent of clk. The first update after deassertion behaves as on an empty table.
- Only one update per cycle. Back-to-back updates to the same entry each apply in order.

## Test plan
- Reset then if_pc=0x0000_0040 -> pred_hit=0, pred_taken=0, pred_target=0, mispredict_cnt=0.
- Update {pc=0x40, taken=1, target=0x20, pred=0} -> next cycle, if_pc=0x40 gives hit=1, taken=1, target=0x20 (ctr=2). mispredict=1 for one cycle; mispredict_cnt=1.
- Saturation: on pc=0x40, apply 3 taken updates (ctr→3) then 2 not-taken (ctr→1). Expected: pred_taken=0 with hit=1. Two further not-taken updates leave ctr=0; then one taken update gives ctr=1, pred_taken=0.
- Aliasing: with IDX_W=4, allocate 0x40, then taken update at 0x440 (same index, different tag). Expected: if_pc=0x40 misses; if_pc=0x440 hits with the new target.
- Same-cycle read/write: if_pc=0x80 while the first taken update for 0x80 is applied. Expected: pred_hit=0 that cycle and 1 the next.
- Counter saturation: force CNT_W=4 and apply 17 mispredicting updates -> mispredict_cnt=4'hF, held. rst_n pulse mid-sequence clears it to 0 asynchronously.
